// File: rtl/ram_read_credit_ctrl_if.sv
// Bundle of request, RAM-stage and result signals for ram_read_credit_ctrl.
// slave = controller view, master = surrounding pipeline / testbench view.
interface ram_read_credit_ctrl_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 6,
    parameter int BYPASS_WIDTH = 1
);
    // Handshakes: a transfer happens on a cycle where valid && ready are both 1;
    // valid never waits on ready, and the RAM stage itself has no ready at all.
    logic [ADDR_WIDTH-1:0]   req_addr_i;
    logic [BYPASS_WIDTH-1:0] req_bypass_i;
    logic                    req_valid_i;
    logic                    req_ready_o;
    logic [ADDR_WIDTH-1:0]   ram_read_addr_o;
    logic [BYPASS_WIDTH-1:0] ram_bypass_o;
    logic                    ram_valid_o;
    logic [DATA_WIDTH-1:0]   ram_read_data_i;
    logic [BYPASS_WIDTH-1:0] ram_bypass_i;
    logic                    ram_valid_i;
    logic [DATA_WIDTH-1:0]   out_read_data_o;
    logic [BYPASS_WIDTH-1:0] out_bypass_o;
    logic                    out_valid_o;
    logic                    out_ready_i;
    logic                    err_o;

    modport slave (
        input  req_addr_i, req_bypass_i, req_valid_i,
        output req_ready_o,
        output ram_read_addr_o, ram_bypass_o, ram_valid_o,
        input  ram_read_data_i, ram_bypass_i, ram_valid_i,
        output out_read_data_o, out_bypass_o, out_valid_o,
        input  out_ready_i,
        output err_o
    );

    modport master (
        output req_addr_i, req_bypass_i, req_valid_i,
        input  req_ready_o,
        input  ram_read_addr_o, ram_bypass_o, ram_valid_o,
        output ram_read_data_i, ram_bypass_i, ram_valid_i,
        input  out_read_data_o, out_bypass_o, out_valid_o,
        output out_ready_i,
        input  err_o
    );
endinterface

// File: rtl/ram_read_credit_ctrl.sv
// Credit-gated issue into a fixed-latency, non-stallable RAM stage with a FWFT result FIFO.
// Optional protocol checker enabled by defining RAM_CREDIT_ERR_CHECK_EN.
module ram_read_credit_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 6,
    parameter int BYPASS_WIDTH = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input logic                  clk_i,
    input logic                  rst_i,
    ram_read_credit_ctrl_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = DATA_WIDTH + BYPASS_WIDTH;
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
    localparam logic [PTR_W-1:0] ONE_P  = PTR_W'(1);
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(FIFO_DEPTH);

    logic             init_q, init_d;
    logic [CNT_W-1:0] credit_q, credit_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
    logic [ENT_W-1:0] mem_d [FIFO_DEPTH];

    logic req_ready, issue, empty, full, pop, wr_en;

    always_comb begin
        req_ready = init_q && (credit_q != '0);
        issue     = bus.req_valid_i && req_ready;
        empty     = (count_q == '0);
        full      = (count_q == FULL_C);
        pop       = !empty && bus.out_ready_i;
        // A full FIFO still accepts a write in the same cycle it pops.
        wr_en     = bus.ram_valid_i && (!full || pop);

        init_d   = 1'b1;
        credit_d = credit_q;
        if (issue && !pop) begin
            credit_d = credit_q - ONE_C;
        end else if (pop && !issue) begin
            credit_d = credit_q + ONE_C;
        end

        count_d  = count_q + CNT_W'(wr_en) - CNT_W'(pop);
        wr_ptr_d = wr_en ? wr_ptr_q + ONE_P : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + ONE_P : rd_ptr_q;

        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = {bus.ram_read_data_i, bus.ram_bypass_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            init_q   <= 1'b0;
            credit_q <= FULL_C;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            init_q   <= init_d;
            credit_q <= credit_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

    // Issue is a straight passthrough: the RAM stage registers the request itself.
    assign bus.req_ready_o     = req_ready;
    assign bus.ram_valid_o     = issue;
    assign bus.ram_read_addr_o = bus.req_addr_i;
    assign bus.ram_bypass_o    = bus.req_bypass_i;

    assign bus.out_valid_o                         = !empty;
    assign {bus.out_read_data_o, bus.out_bypass_o} = mem_q[rd_ptr_q];

`ifdef RAM_CREDIT_ERR_CHECK_EN
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic             err_q, err_d;
    logic             ret_ok;

    // Outstanding = issued but not yet returned by the RAM stage.
    always_comb begin
        ret_ok        = bus.ram_valid_i && (outstanding_q != '0);
        outstanding_d = outstanding_q + CNT_W'(issue) - CNT_W'(ret_ok);
        err_d         = err_q;
        if (bus.ram_valid_i && ((outstanding_q == '0) || (full && !pop))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
        end
    end

    assign bus.err_o = err_q;
`else
    assign bus.err_o = 1'b0;
`endif
endmodule

// File: tb/tb_ram_read_credit_ctrl.sv
// Directed + random bench for ram_read_credit_ctrl with a 2-cycle RAM stage model and scoreboard.
module tb_ram_read_credit_ctrl;
    localparam int DW = 8;
    localparam int AW = 6;
    localparam int BW = 1;
`ifdef RAM_CREDIT_ERR_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic clk_i;
    logic rst_i;

    ram_read_credit_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS_WIDTH(BW)) bus ();

    ram_read_credit_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS_WIDTH(BW), .FIFO_DEPTH(4)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    // clock / reset
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int issue_cnt = 0;
    int pop_cnt = 0;
    logic [DW+BW-1:0] exp_q[$];

    function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
        logic [DW-1:0] t;
        t = {2'b00, a};
        return (t * 8'd37) ^ 8'h5A;
    endfunction

    // RAM stage model: fixed latency 2, in order
    logic          p1_v, p2_v, inject;
    logic [AW-1:0] p1_a, p2_a;
    logic [BW-1:0] p1_b, p2_b;
    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            p1_v <= 1'b0; p2_v <= 1'b0;
            p1_a <= '0;   p2_a <= '0;
            p1_b <= '0;   p2_b <= '0;
        end else begin
            p1_v <= bus.ram_valid_o; p1_a <= bus.ram_read_addr_o; p1_b <= bus.ram_bypass_o;
            p2_v <= p1_v;            p2_a <= p1_a;                p2_b <= p1_b;
        end
    end
    assign bus.ram_valid_i     = p2_v | inject;
    assign bus.ram_read_data_i = mem_f(p2_a);
    assign bus.ram_bypass_i    = p2_b;

    // scoreboard: push on issue, pop/compare on output transfer
    always @(negedge clk_i) begin
        if (rst_i) begin
            if (bus.out_valid_o && bus.out_ready_i) begin
                pop_cnt++;
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL out_unexpected observed %0h expected none",
                           {bus.out_read_data_o, bus.out_bypass_o});
                end
                if (exp_q.size() != 0) begin
                    logic [DW+BW-1:0] e, o;
                    e = exp_q.pop_front();
                    o = {bus.out_read_data_o, bus.out_bypass_o};
                    checks++;
                    assert (o === e) else begin
                        errors++;
                        $error("FAIL out_data observed %0h expected %0h", o, e);
                    end
                end
            end
            if (bus.req_valid_i && bus.req_ready_o) begin
                issue_cnt++;
                exp_q.push_back({mem_f(bus.req_addr_i), bus.req_bypass_i});
            end
        end
    end

    // driver tasks
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        bus.req_valid_i = 1'b0;
        bus.out_ready_i = 1'b1;
        while ((exp_q.size() != 0 || bus.out_valid_o) && n < 200) begin
            cyc();
            n++;
        end
        chk({tag, "_queue_empty"}, exp_q.size(), 0);
        chk({tag, "_out_valid"}, bus.out_valid_o, 0);
    endtask

    task automatic fill_stall();
        bus.out_ready_i = 1'b0;
        bus.req_valid_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.req_addr_i   = AW'($urandom_range(0, 63));
            bus.req_bypass_i = BW'($urandom_range(0, 1));
            #0;
            chk("stall_ready", bus.req_ready_o, (k < 4) ? 1 : 0);
            cyc();
        end
    endtask

    initial begin
        int base_i, base_p, c0;
        rst_i            = 1'b0;
        inject           = 1'b0;
        bus.req_addr_i   = '0;
        bus.req_bypass_i = '0;
        bus.req_valid_i  = 1'b1;
        bus.out_ready_i  = 1'b1;

        // reset values
        repeat (3) cyc();
        chk("rst_ready",      bus.req_ready_o, 0);
        chk("rst_ram_valid",  bus.ram_valid_o, 0);
        chk("rst_out_valid",  bus.out_valid_o, 0);
        chk("rst_err",        bus.err_o, 0);
        chk("rst_credit",     dut.credit_q, 4);
        chk("rst_out_data",   {bus.out_read_data_o, bus.out_bypass_o}, 0);
        bus.req_valid_i = 1'b0;
        rst_i = 1'b1;
        chk("rel_ready_c0", bus.req_ready_o, 0);
        cyc();
        chk("rel_ready_c1", bus.req_ready_o, 1);
        chk("rel_credit",   dut.credit_q, 4);

        // streaming addrs 0..7, L=2
        base_p = pop_cnt;
        bus.req_valid_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.req_addr_i   = AW'(i);
            bus.req_bypass_i = BW'(i & 1);
            chk("stream_ready", bus.req_ready_o, 1);
            chk("stream_out_valid", bus.out_valid_o, (i >= 3) ? 1 : 0);
            cyc();
        end
        bus.req_valid_i = 1'b0;
        for (int j = 8; j < 12; j++) begin
            chk("stream_tail_valid", bus.out_valid_o, (j < 11) ? 1 : 0);
            cyc();
        end
        chk("stream_pops", pop_cnt - base_p, 8);
        chk("stream_credit", dut.credit_q, 4);

        // stall then drain with credits returning one per pop
        base_i = issue_cnt;
        fill_stall();
        chk("stall_issued", issue_cnt - base_i, 4);
        chk("stall_fifo_count", dut.count_q, 4);
        chk("stall_credit", dut.credit_q, 0);
        chk("stall_out_valid", bus.out_valid_o, 1);
        bus.req_valid_i = 1'b0;
        bus.out_ready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("drain_credit", dut.credit_q, k);
            chk("drain_out_valid", bus.out_valid_o, (k < 4) ? 1 : 0);
            cyc();
        end

        // pop at credit 0 with full FIFO, then issue+pop together
        fill_stall();
        bus.out_ready_i = 1'b1;
        chk("zero_credit", dut.credit_q, 0);
        chk("zero_ready", bus.req_ready_o, 0);
        cyc();
        chk("after_pop_credit", dut.credit_q, 1);
        chk("after_pop_ready", bus.req_ready_o, 1);
        cyc();
        chk("issue_pop_credit", dut.credit_q, 1);
        drain("simul");

        // random bypass / backpressure, 1000 requests
        base_i = issue_cnt;
        base_p = pop_cnt;
        c0 = 0;
        while ((issue_cnt - base_i) < 1000 && c0 < 20000) begin
            bus.req_valid_i  = ($urandom_range(0, 3) != 0);
            bus.req_addr_i   = AW'($urandom_range(0, 63));
            bus.req_bypass_i = BW'($urandom_range(0, 1));
            bus.out_ready_i  = ($urandom_range(0, 2) != 0);
            cyc();
            c0++;
        end
        chk("rand_issued", issue_cnt - base_i, 1000);
        drain("rand");
        chk("rand_pops", pop_cnt - base_p, 1000);
        chk("rand_err_clear", bus.err_o, 0);

        // spurious RAM return with nothing outstanding
        bus.out_ready_i = 1'b0;
        inject = 1'b1;
        cyc();
        inject = 1'b0;
        chk("err_set", bus.err_o, ERR_EXP);
        repeat (3) cyc();
        chk("err_sticky", bus.err_o, ERR_EXP);
        rst_i = 1'b0;
        #1;
        chk("err_reset", bus.err_o, 0);
        chk("mid_rst_out_valid", bus.out_valid_o, 0);
        chk("mid_rst_credit", dut.credit_q, 4);
        chk("mid_rst_ready", bus.req_ready_o, 0);
        cyc();
        rst_i = 1'b1;
        cyc();
        chk("rerel_ready", bus.req_ready_o, 1);

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_read_credit_ctrl.md
# ram_read_credit_ctrl

Credit-based flow-control wrapper for the non-stallable RAM read stage of the quadtree lookup pipeline. Accepts read requests over a valid/ready handshake and issues them into the fixed-latency RAM stage only when the output FIFO has guaranteed room. RAM results (data + bypass) are captured in an output FIFO and presented downstream with valid/ready backpressure. Sits directly upstream and downstream of the RAM-with-delay stage: it drives that stage's read inputs and consumes its outputs.

## Interface
Parameters:
- DATA_WIDTH, 8, RAM read data width.
- ADDR_WIDTH, 6, RAM read address width.
- BYPASS_WIDTH, 1, sideband carried alongside each request.
- FIFO_DEPTH, 4, output FIFO entries; power of two, >= 2.

Ports:
- clk_i  in  1  clock; one clock domain.
- rst_i  in  1  reset, asynchronous, active-low.
- req_addr_i  in  ADDR_WIDTH  request read address.
- req_bypass_i  in  BYPASS_WIDTH  request sideband.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid && ready.
- ram_read_addr_o  out  ADDR_WIDTH  to RAM stage read address.
- ram_bypass_o  out  BYPASS_WIDTH  to RAM stage bypass.
- ram_valid_o  out  1  to RAM stage valid.
- ram_read_data_i  in  DATA_WIDTH  from RAM stage read data.
- ram_bypass_i  in  BYPASS_WIDTH  from RAM stage bypass.
- ram_valid_i  in  1  from RAM stage valid.
- out_read_data_o  out  DATA_WIDTH  result data.
- out_bypass_o  out  BYPASS_WIDTH  result sideband.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream accepts when valid && ready.
- err_o  out  1  sticky protocol error.

## Operation
- Credit counter, width clog2(FIFO_DEPTH)+1, reset to FIFO_DEPTH. One credit = one FIFO slot reserved for a request either in flight in the RAM stage or stored in the FIFO.
- init flag: reset 0, set 1 on first clk_i edge after rst_i deasserts. req_ready_o = init && (credit != 0).
- Issue: issue = req_valid_i && req_ready_o. ram_valid_o = issue; ram_read_addr_o = req_addr_i; ram_bypass_o = req_bypass_i (combinational passthrough, no issue register).
- Credit update per cycle: issue only -> -1; pop only -> +1; both or neither -> unchanged. pop = out_valid_o && out_ready_i.
- FIFO: first-word-fall-through, write on ram_valid_i of {ram_read_data_i, ram_bypass_i}, read on pop. Simultaneous write and read on a full or empty FIFO are both legal (empty: written word appears next cycle, no same-cycle bypass). Pointers wrap modulo FIFO_DEPTH.
- out_valid_o = FIFO not empty; out data = head entry; head data unspecified when empty.
- Ordering: results leave in request-issue order; the RAM stage is in-order with fixed latency, so no tags.
- Any RAM-stage latency is supported without retuning, because credits cover in-flight requests.

## Timing
- Reset values: req_ready_o 0, ram_valid_o 0, out_valid_o 0, err_o 0, credit FIFO_DEPTH, FIFO empty. Data outputs reset to 0.
- req_ready_o rises one cycle after rst_i deasserts.
- Request to result: RAM-stage latency L, plus 1 cycle FIFO write, so out_valid_o is high L+1 cycles after issue when the FIFO was empty.
- Throughput: 1 request/cycle sustained while out_ready_i is high.
- Back-pressure bound: after out_ready_i drops, at most `credit` further requests are issued, then req_ready_o goes 0.
- Reset mid-operation: all state clears asynchronously. In-flight RAM results arriving after reset release are written into the FIFO and flagged: err_o is set if ram_valid_i arrives with no outstanding request.

## Configuration
- RAM_CREDIT_ERR_CHECK_EN:
  - Defined: checker tracks the outstanding count (issued but not yet written). err_o sets and stays set until reset on either of:
    - ram_valid_i while outstanding == 0;
    - ram_valid_i while the FIFO is full and not popping; the write is dropped.
  - Undefined: checker is not built and err_o is tied 0; overflow behaviour is undefined.

## Test plan
- Reset release: rst_i high at cycle 0 -> req_ready_o 0 at cycle 0, 1 at cycle 1; credit 4; out_valid_o 0.
- Streaming, L=2, out_ready_i=1, addrs 0..7 back-to-back -> out data RAM[0..7] in order, first valid 3 cycles after first issue, no bubbles, req_ready_o stays 1.
- Stall, out_ready_i=0, continuous requests -> exactly 4 issued, req_ready_o 0 from then on, FIFO fills to 4 entries. Release out_ready_i -> drains 4 results, credits return one per pop.
- Simultaneous issue and pop at credit 0 with FIFO full -> credit stays 0 that cycle; next cycle credit 1, req_ready_o 1.
- Bypass integrity: random bypass values with random out_ready_i -> each out_bypass_o matches its request's bypass, 1000 requests with zero mismatches.
- With RAM_CREDIT_ERR_CHECK_EN: inject ram_valid_i with nothing outstanding -> err_o 1 next cycle and stays 1 until rst_i asserted.
